// File: rtl/linear_proj_pkg.sv
// Shared geometry for the linear projection C write path: tile shape, BRAM word
// width and address sizing derived from the systolic array configuration.
package linear_proj_pkg;

  localparam int WIDTH_OUT     = 16;
  localparam int BLOCK_SIZE    = 2;
  localparam int CHUNK_SIZE    = 4;
  localparam int NUM_CORES_A   = 2;
  localparam int NUM_CORES_B   = 1;
  localparam int TOTAL_INPUT_W = 2;
  localparam int TOTAL_MODULES = 4;

  localparam int DEF_A_OUTER_DIMENSION = 8;
  localparam int DEF_B_OUTER_DIMENSION = 8;

  localparam int TILE_ROWS      = BLOCK_SIZE * NUM_CORES_A * TOTAL_INPUT_W;
  localparam int TILE_COLS      = BLOCK_SIZE * NUM_CORES_B * TOTAL_MODULES;
  localparam int TILE_W         = TILE_ROWS * TILE_COLS * WIDTH_OUT;
  localparam int DATA_WIDTH_C   = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A;
  localparam int BEATS_PER_TILE = TILE_W / DATA_WIDTH_C;

  // Number of tiles that make up one C matrix of the given outer dimensions.
  function automatic int calc_max_flag(input int a_dim, input int b_dim);
    return (a_dim / TILE_ROWS) * (b_dim / TILE_COLS);
  endfunction

  function automatic int calc_addr_width(input int max_flag);
    int w;
    w = $clog2(max_flag * BEATS_PER_TILE);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int MAX_FLAG     = calc_max_flag(DEF_A_OUTER_DIMENSION, DEF_B_OUTER_DIMENSION);
  localparam int ADDR_WIDTH_C = calc_addr_width(MAX_FLAG);

  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_WRITE, C_DONE} c_wr_state_t;

endpackage

// File: rtl/linear_proj_c_addr_gen.sv
// Beat and tile counters for the C writer; produces the registered BRAM word
// address and the last-beat / last-tile flags consumed by the writer FSM.
module linear_proj_c_addr_gen #(
  parameter int BEATS  = 8,
  parameter int TILES  = 1,
  parameter int ADDR_W = 3,
  parameter int BEAT_W = 3,
  parameter int TIDX_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  output logic [BEAT_W-1:0] beat,
  output logic [ADDR_W-1:0] addr,
  output logic              last_beat,
  output logic              last_tile
);

  logic [TIDX_W-1:0] tile_idx;
  logic [ADDR_W-1:0] base;

  assign base      = ADDR_W'(int'(tile_idx) * BEATS);
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign last_tile = (tile_idx == TIDX_W'(TILES - 1));

  // tile_idx may reach TILES after the final tile; it only returns to 0 via clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= '0;
      tile_idx <= '0;
      addr     <= '0;
    end else if (clear) begin
      beat     <= '0;
      tile_idx <= '0;
      addr     <= '0;
    end else if (load) begin
      beat <= '0;
      addr <= base;
    end else if (step) begin
      if (last_beat) begin
        beat     <= '0;
        tile_idx <= tile_idx + TIDX_W'(1);
      end else begin
        beat <= beat + BEAT_W'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/linear_proj_c_writer.sv
// Captures finished C tiles on a valid/ready handshake and streams them into
// the C BRAM one DATA_WIDTH_C word per cycle at linear addresses.
//
// state   | meaning
// C_IDLE  | after reset, waiting for start
// C_WAIT  | armed, in_ready high, waiting for a tile
// C_WRITE | streaming the captured tile, one beat per cycle
// C_DONE  | all tiles of the matrix written, done high until next start
module linear_proj_c_writer
  import linear_proj_pkg::*;
#(
  parameter int A_OUTER_DIMENSION = DEF_A_OUTER_DIMENSION,
  parameter int B_OUTER_DIMENSION = DEF_B_OUTER_DIMENSION,
  localparam int N_TILES = calc_max_flag(A_OUTER_DIMENSION, B_OUTER_DIMENSION),
  localparam int ADDR_W  = calc_addr_width(N_TILES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TILE_W-1:0]       in_tile,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_WIDTH_C-1:0] wr_data,
  output logic                    busy,
  output logic                    done
);

  localparam int BEAT_W = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1;
  localparam int TIDX_W = $clog2(N_TILES + 1);

  c_wr_state_t state_q, state_d;

  logic [BEATS_PER_TILE-1:0][DATA_WIDTH_C-1:0] tile_q;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic              last_beat, last_tile;
  logic              hs, clear, step;

  // in_ready is high exactly in C_WAIT, so it doubles as the state qualifier here.
  assign hs       = in_valid && in_ready;
  assign clear    = start && ((state_q == C_IDLE) || (state_q == C_DONE));
  assign step     = (state_q == C_WRITE);
  assign beat_nxt = beat + BEAT_W'(1);

  linear_proj_c_addr_gen #(
    .BEATS (BEATS_PER_TILE),
    .TILES (N_TILES),
    .ADDR_W(ADDR_W),
    .BEAT_W(BEAT_W),
    .TIDX_W(TIDX_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .load     (hs),
    .step     (step),
    .beat     (beat),
    .addr     (wr_addr),
    .last_beat(last_beat),
    .last_tile(last_tile)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (start) state_d = C_WAIT;
      C_WAIT:  if (hs) state_d = C_WRITE;
      C_WRITE: if (last_beat) state_d = last_tile ? C_DONE : C_WAIT;
      C_DONE:  if (start) state_d = C_WAIT;
      default: state_d = C_IDLE;
    endcase
  end

  // Status and write strobes are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= C_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      tile_q   <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == C_WAIT);
      busy     <= (state_d == C_WAIT) || (state_d == C_WRITE);
      done     <= (state_d == C_DONE);
      wr_en    <= (state_d == C_WRITE);
      if (hs) begin
        tile_q  <= in_tile;
        wr_data <= in_tile[DATA_WIDTH_C-1:0];
      end else if ((state_q == C_WRITE) && !last_beat) begin
        wr_data <= tile_q[beat_nxt];
      end
    end
  end

endmodule
